// File: rtl/csr_pkg.sv
// csr_pkg: shared constants and types for the machine-mode CSR unit.
// Holds CSR address constants, the csr_ctrl operation encoding, the WFI
// state encoding, the fixed trap vector and the field bit positions of
// mstatus / mie / mip.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

  localparam logic [31:0] MTVEC_RESET = 32'h0001_0000;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;
  localparam int MIP_MTIP_BIT     = 7;

  typedef enum logic [3:0] {
    CSR_RW       = 4'd0,
    CSR_RS       = 4'd1,
    CSR_RC       = 4'd2,
    CSR_RWI      = 4'd3,
    CSR_RSI      = 4'd4,
    CSR_RCI      = 4'd5,
    CSR_CYCLE    = 4'd6,
    CSR_INSTRET  = 4'd7,
    CSR_CYCLEH   = 4'd8,
    CSR_INSTRETH = 4'd9
  } csr_ctrl_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WFI_WAIT = 1'b1
  } csr_state_e;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit free-running counter with per-half write access.
// Ports:
//   clk, rstn     - clock, asynchronous active-low reset
//   inc           - advance by one this cycle
//   wr_lo, wr_hi  - load wdata into the low / high 32 bits
//   wdata         - write data
//   count         - current 64-bit value
// A write to either half replaces that cycle's increment for the whole
// counter, so the untouched half holds rather than taking a carry.
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // Counter register: writes take priority over the increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (wr_lo) begin
      count <= {count[63:32], wdata};
    end else if (wr_hi) begin
      count <= {wdata, count[31:0]};
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with interrupt take, MRET and WFI sleep.
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   csr_valid, csr_we         - CSR instruction in EX and its write enable
//   csr_ctrl, csr_addr        - operation (RW/RS/RC/imm forms, counter reads), CSR address
//   rs1_data, uimm            - register / immediate write source
//   mret, wfi, pc_ex          - MRET / WFI in EX and the EX PC
//   stall                     - pipeline or memory wait, freezes architectural CSRs
//   retire                    - instruction retired pulse (minstret)
//   ext_irq, tmr_irq          - external / timer interrupt lines
//   csr_rdata                 - old CSR value (combinational)
//   trap_taken, mret_taken    - one-cycle redirect pulses
//   redirect_pc               - target PC for the pulse, 0 otherwise
//   wfi_stall                 - high while sleeping in WFI
// Build option: define CSR_IRQ_SYNC_EN to pass the interrupt lines through a
// two-flop synchronizer (mip latency 2); otherwise one register (latency 1).
module csr_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        csr_valid,
  input  logic        csr_we,
  input  logic [3:0]  csr_ctrl,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  input  logic [4:0]  uimm,
  input  logic        mret,
  input  logic        wfi,
  input  logic [31:0] pc_ex,
  input  logic        stall,
  input  logic        retire,
  input  logic        ext_irq,
  input  logic        tmr_irq,
  output logic [31:0] csr_rdata,
  output logic        trap_taken,
  output logic        mret_taken,
  output logic [31:0] redirect_pc,
  output logic        wfi_stall
);

  csr_state_e  state, state_nxt;
  csr_ctrl_e   ctrl;
  logic        meip, mtip;
  logic        mst_mie, mst_mpie, mie_meie, mie_mtie;
  logic [31:0] mepc, wfi_pc;
  logic [63:0] mcycle, minstret;
  logic [31:0] mstatus_val, mie_val, mip_val, old_val, src, new_val;
  logic        irq_pend, take, mret_go, we_en;
  logic        wr_mstatus, wr_mie, wr_mepc;
  logic        cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;

  assign ctrl = csr_ctrl_e'(csr_ctrl);

`ifdef CSR_IRQ_SYNC_EN
  logic ext_meta, tmr_meta;

  // Two-flop synchronizer for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext_meta <= 1'b0;
      tmr_meta <= 1'b0;
      meip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      ext_meta <= ext_irq;
      tmr_meta <= tmr_irq;
      meip     <= ext_meta;
      mtip     <= tmr_meta;
    end
  end
`else
  // Single register stage: lines are assumed synchronous to clk.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meip <= 1'b0;
      mtip <= 1'b0;
    end else begin
      meip <= ext_irq;
      mtip <= tmr_irq;
    end
  end
`endif

  // Assemble the architectural views of the sparse CSRs.
  always_comb begin
    mstatus_val = '0;
    mstatus_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    mstatus_val[MSTATUS_MIE_BIT]  = mst_mie;
    mstatus_val[MSTATUS_MPIE_BIT] = mst_mpie;
    mie_val = '0;
    mie_val[MIE_MEIE_BIT] = mie_meie;
    mie_val[MIE_MTIE_BIT] = mie_mtie;
    mip_val = '0;
    mip_val[MIP_MEIP_BIT] = meip;
    mip_val[MIP_MTIP_BIT] = mtip;
  end

  // Address decode of the current (pre-write) value.
  always_comb begin
    old_val = '0;
    case (csr_addr)
      ADDR_MSTATUS:                  old_val = mstatus_val;
      ADDR_MIE:                      old_val = mie_val;
      ADDR_MTVEC:                    old_val = MTVEC_RESET;
      ADDR_MEPC:                     old_val = mepc;
      ADDR_MIP:                      old_val = mip_val;
      ADDR_MCYCLE,    ADDR_CYCLE:    old_val = mcycle[31:0];
      ADDR_MCYCLEH,   ADDR_CYCLEH:   old_val = mcycle[63:32];
      ADDR_MINSTRET,  ADDR_INSTRET:  old_val = minstret[31:0];
      ADDR_MINSTRETH, ADDR_INSTRETH: old_val = minstret[63:32];
      default:                       old_val = '0;
    endcase
  end

  // Read data: counter-read opcodes bypass the address decode.
  always_comb begin
    csr_rdata = old_val;
    case (ctrl)
      CSR_CYCLE:    csr_rdata = mcycle[31:0];
      CSR_INSTRET:  csr_rdata = minstret[31:0];
      CSR_CYCLEH:   csr_rdata = mcycle[63:32];
      CSR_INSTRETH: csr_rdata = minstret[63:32];
      default:      ;
    endcase
    if (!rstn) csr_rdata = '0;
  end

  // Read-modify-write result for the six CSR instruction forms.
  assign src = (csr_ctrl <= 4'd2) ? rs1_data : {27'd0, uimm};

  always_comb begin
    new_val = old_val;
    case (ctrl)
      CSR_RW, CSR_RWI: new_val = src;
      CSR_RS, CSR_RSI: new_val = old_val | src;
      CSR_RC, CSR_RCI: new_val = old_val & ~src;
      default:         ;
    endcase
  end

  // An interrupt is taken only when globally enabled and the pipeline can
  // move; it pre-empts MRET, WFI entry and writes to the trap CSRs.
  assign irq_pend = (meip & mie_meie) | (mtip & mie_mtie);
  assign take     = irq_pend & mst_mie & ~stall;
  assign mret_go  = mret & ~stall & ~take;
  assign we_en    = csr_valid & csr_we & ~stall & (csr_ctrl <= 4'd5);

  assign wr_mstatus = we_en & ~take & (csr_addr == ADDR_MSTATUS);
  assign wr_mie     = we_en & ~take & (csr_addr == ADDR_MIE);
  assign wr_mepc    = we_en & ~take & (csr_addr == ADDR_MEPC);
  assign cyc_wr_lo  = we_en & (csr_addr == ADDR_MCYCLE);
  assign cyc_wr_hi  = we_en & (csr_addr == ADDR_MCYCLEH);
  assign ins_wr_lo  = we_en & (csr_addr == ADDR_MINSTRET);
  assign ins_wr_hi  = we_en & (csr_addr == ADDR_MINSTRETH);

  // WFI state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Wake-up ignores mstatus.MIE: a locally enabled pending interrupt always
  // ends the sleep, and the take logic decides whether it also traps.
  always_comb begin
    state_nxt = state;
    wfi_stall = 1'b0;
    case (state)
      ST_RUN: begin
        if (wfi && !stall && !take) state_nxt = ST_WFI_WAIT;
      end
      ST_WFI_WAIT: begin
        wfi_stall = 1'b1;
        if (irq_pend) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Resume address for an interrupt that wakes the core from WFI.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wfi_pc <= '0;
    end else if (state == ST_RUN && state_nxt == ST_WFI_WAIT) begin
      wfi_pc <= pc_ex + 32'd4;
    end
  end

  // Trap CSRs: trap entry first, then MRET, then software writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
      mie_meie <= 1'b0;
      mie_mtie <= 1'b0;
      mepc     <= '0;
    end else if (take) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
      mepc     <= ((state == ST_WFI_WAIT) ? wfi_pc : pc_ex) & 32'hFFFF_FFFC;
    end else begin
      if (mret_go) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mst_mie  <= new_val[MSTATUS_MIE_BIT];
        mst_mpie <= new_val[MSTATUS_MPIE_BIT];
      end
      if (wr_mie) begin
        mie_meie <= new_val[MIE_MEIE_BIT];
        mie_mtie <= new_val[MIE_MTIE_BIT];
      end
      if (wr_mepc) mepc <= new_val & 32'hFFFF_FFFC;
    end
  end

  csr_counter64 u_mcycle (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (1'b1),
    .wr_lo (cyc_wr_lo),
    .wr_hi (cyc_wr_hi),
    .wdata (new_val),
    .count (mcycle)
  );

  csr_counter64 u_minstret (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (retire),
    .wr_lo (ins_wr_lo),
    .wr_hi (ins_wr_hi),
    .wdata (new_val),
    .count (minstret)
  );

  // Redirect outputs are forced low while reset is held.
  always_comb begin
    trap_taken  = rstn & take;
    mret_taken  = rstn & mret_go;
    redirect_pc = '0;
    if (rstn) begin
      if (take)         redirect_pc = MTVEC_RESET;
      else if (mret_go) redirect_pc = mepc;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: self-checking bench for csr_unit.
// Table-driven CSR operation vectors, hand-written interrupt / MRET / WFI
// sequences and a randomized phase against a field-level reference model.
// Honours CSR_IRQ_SYNC_EN for the expected interrupt latency.
module tb_csr_unit;

`ifdef CSR_IRQ_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        csr_valid, csr_we;
  logic [3:0]  csr_ctrl;
  logic [11:0] csr_addr;
  logic [31:0] rs1_data;
  logic [4:0]  uimm;
  logic        mret, wfi;
  logic [31:0] pc_ex;
  logic        stall, retire, ext_irq, tmr_irq;
  logic [31:0] csr_rdata, redirect_pc;
  logic        trap_taken, mret_taken, wfi_stall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  ctrl;
    logic [11:0] addr;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic [31:0] exp_old;
    logic [31:0] exp_new;
  } vec_t;

  vec_t vecs[14];

  logic [11:0] addrs[14] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h344,
                             12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00,
                             12'hC02, 12'hC80, 12'hC82, 12'h7C0};

  // Reference model: architectural fields only.
  logic        m_mie, m_mpie, m_meie, m_mtie;
  logic [31:0] m_mepc;
  logic [63:0] m_cycle, m_instret;

  always #5 clk = ~clk;

  csr_unit dut (
    .clk         (clk),
    .rstn        (rstn),
    .csr_valid   (csr_valid),
    .csr_we      (csr_we),
    .csr_ctrl    (csr_ctrl),
    .csr_addr    (csr_addr),
    .rs1_data    (rs1_data),
    .uimm        (uimm),
    .mret        (mret),
    .wfi         (wfi),
    .pc_ex       (pc_ex),
    .stall       (stall),
    .retire      (retire),
    .ext_irq     (ext_irq),
    .tmr_irq     (tmr_irq),
    .csr_rdata   (csr_rdata),
    .trap_taken  (trap_taken),
    .mret_taken  (mret_taken),
    .redirect_pc (redirect_pc),
    .wfi_stall   (wfi_stall)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkFlag(input string name, input logic actual, input logic expected);
    checkOutput(name, {31'd0, actual}, {31'd0, expected});
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [3:0] c,
                               input logic [11:0] a, input logic [31:0] r, input logic [4:0] u);
    csr_valid = v;
    csr_we    = w;
    csr_ctrl  = c;
    csr_addr  = a;
    rs1_data  = r;
    uimm      = u;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'd0, 12'h000, 32'd0, 5'd0);
  endtask

  task automatic writeCsr(input logic [3:0] c, input logic [11:0] a, input logic [31:0] r, input logic [4:0] u);
    applyStimulus(1'b1, 1'b1, c, a, r, u);
    tick();
    idle();
  endtask

  task automatic readCsr(input string name, input logic [11:0] a, input logic [31:0] expected);
    applyStimulus(1'b1, 1'b0, 4'd1, a, 32'd0, 5'd0);
    #1;
    checkOutput(name, csr_rdata, expected);
    idle();
  endtask

  task automatic doReset();
    rstn = 1'b0;
    idle();
    mret = 1'b0; wfi = 1'b0; pc_ex = 32'd0; stall = 1'b0;
    retire = 1'b0; ext_irq = 1'b0; tmr_irq = 1'b0;
    m_mie = 1'b0; m_mpie = 1'b0; m_meie = 1'b0; m_mtie = 1'b0;
    m_mepc = 32'd0; m_cycle = 64'd0; m_instret = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Sleeps until wfi_stall drops; raises tmr_irq once 9 sleep cycles have passed.
  task automatic runWfi(output int cycles, output logic trap_seen);
    cycles = 0;
    trap_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cycles == 9) tmr_irq = 1'b1;
      #1;
      if (!wfi_stall) break;
      cycles++;
      if (trap_taken) trap_seen = 1'b1;
      tick();
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [11:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      12'h300: begin
        v[12:11] = 2'b11;
        v[7] = m_mpie;
        v[3] = m_mie;
      end
      12'h304: begin
        v[11] = m_meie;
        v[7]  = m_mtie;
      end
      12'h305: v = 32'h0001_0000;
      12'h341: v = m_mepc;
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  initial begin
    #500000;
    $display("[TB] watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int          cyc;
    logic        tseen;
    logic [3:0]  c;
    logic [11:0] a;
    logic [31:0] r, s_src, oldv, newv, expv;
    logic [4:0]  u;
    logic        v, w, s, rt, cw, iw;

    vecs[0]  = '{4'd0, 12'h341, 32'h1234_5678, 5'd0,  32'h0000_0000, 32'h1234_5678};
    vecs[1]  = '{4'd1, 12'h341, 32'h0000_0003, 5'd0,  32'h1234_5678, 32'h1234_5678};
    vecs[2]  = '{4'd2, 12'h341, 32'hFFFF_0000, 5'd0,  32'h1234_5678, 32'h0000_5678};
    vecs[3]  = '{4'd3, 12'h300, 32'hFFFF_FFFF, 5'd8,  32'h0000_1800, 32'h0000_1808};
    vecs[4]  = '{4'd1, 12'h300, 32'h0000_0080, 5'd0,  32'h0000_1808, 32'h0000_1888};
    vecs[5]  = '{4'd5, 12'h300, 32'hFFFF_FFFF, 5'd8,  32'h0000_1888, 32'h0000_1880};
    vecs[6]  = '{4'd0, 12'h304, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 32'h0000_0880};
    vecs[7]  = '{4'd2, 12'h304, 32'h0000_0800, 5'd0,  32'h0000_0880, 32'h0000_0080};
    vecs[8]  = '{4'd4, 12'h304, 32'h0000_0000, 5'd31, 32'h0000_0080, 32'h0000_0080};
    vecs[9]  = '{4'd0, 12'h305, 32'h0000_0000, 5'd0,  32'h0001_0000, 32'h0001_0000};
    vecs[10] = '{4'd0, 12'h123, 32'h0000_DEAD, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[11] = '{4'd0, 12'h344, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{4'd0, 12'hC02, 32'h0000_0055, 5'd0,  32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{4'd0, 12'h300, 32'hFFFF_FFFF, 5'd0,  32'h0000_1880, 32'h0000_1888};

    // Outputs held at zero during reset, even with MRET and a read requested.
    rstn = 1'b1;
    idle();
    wfi = 1'b0; pc_ex = 32'd0; stall = 1'b0; retire = 1'b0;
    ext_irq = 1'b0; tmr_irq = 1'b0; mret = 1'b0;
    #2;
    rstn = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd1, 12'h300, 32'd0, 5'd0);
    mret = 1'b1;
    #1;
    checkOutput("reset_rdata", csr_rdata, 32'd0);
    checkFlag("reset_trap", trap_taken, 1'b0);
    checkFlag("reset_mret", mret_taken, 1'b0);
    checkOutput("reset_redirect", redirect_pc, 32'd0);
    checkFlag("reset_wfi_stall", wfi_stall, 1'b0);

    $display("[TB] table-driven CSR operations");
    doReset();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 1'b1, vecs[i].ctrl, vecs[i].addr, vecs[i].rs1, vecs[i].uimm);
      #1;
      checkOutput($sformatf("vec%0d_old", i), csr_rdata, vecs[i].exp_old);
      tick();
      readCsr($sformatf("vec%0d_new", i), vecs[i].addr, vecs[i].exp_new);
    end

    $display("[TB] mcycle carry into high half");
    doReset();
    writeCsr(4'd0, 12'hB80, 32'd0, 5'd0);
    writeCsr(4'd0, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    applyStimulus(1'b1, 1'b0, 4'd6, 12'h000, 32'd0, 5'd0); #1;
    checkOutput("mcycle_lo_after_write", csr_rdata, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 1'b0, 4'd8, 12'h000, 32'd0, 5'd0); #1;
    checkOutput("mcycle_hi_after_write", csr_rdata, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd6, 12'h000, 32'd0, 5'd0); #1;
    checkOutput("mcycle_lo_wrap", csr_rdata, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'd8, 12'h000, 32'd0, 5'd0); #1;
    checkOutput("mcycle_hi_carry", csr_rdata, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 4'd6, 12'h000, 32'd0, 5'd0); #1;
    checkOutput("mcycle_lo_next", csr_rdata, 32'd1);
    readCsr("cycleh_alias", 12'hC80, 32'd1);

    $display("[TB] external interrupt then MRET");
    doReset();
    writeCsr(4'd3, 12'h300, 32'd0, 5'd8);
    writeCsr(4'd0, 12'h304, 32'h0000_0800, 5'd0);
    pc_ex = 32'h200;
    ext_irq = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      checkFlag("irq_latency_no_trap", trap_taken, 1'b0);
      tick();
    end
    #1;
    checkFlag("irq_trap_taken", trap_taken, 1'b1);
    checkOutput("irq_redirect", redirect_pc, 32'h0001_0000);
    checkFlag("irq_no_mret", mret_taken, 1'b0);
    tick();
    #1;
    checkFlag("irq_trap_one_cycle", trap_taken, 1'b0);
    checkOutput("irq_redirect_idle", redirect_pc, 32'd0);
    ext_irq = 1'b0;
    readCsr("irq_mepc", 12'h341, 32'h200);
    readCsr("irq_mstatus", 12'h300, 32'h0000_1880);
    repeat (LAT + 1) tick();
    mret = 1'b1;
    #1;
    checkFlag("mret_taken", mret_taken, 1'b1);
    checkFlag("mret_no_trap", trap_taken, 1'b0);
    checkOutput("mret_redirect", redirect_pc, 32'h200);
    tick();
    mret = 1'b0;
    readCsr("mret_mstatus", 12'h300, 32'h0000_1888);

    $display("[TB] WFI with interrupts globally disabled, then enabled");
    doReset();
    writeCsr(4'd0, 12'h304, 32'h0000_0080, 5'd0);
    pc_ex = 32'h300;
    wfi = 1'b1;
    #1;
    checkFlag("wfi_entry_no_stall", wfi_stall, 1'b0);
    tick();
    wfi = 1'b0;
    pc_ex = 32'h308;
    runWfi(cyc, tseen);
    checkOutput("wfi_sleep_cycles", cyc, 32'(10 + LAT));
    checkFlag("wfi_wake_no_trap", tseen, 1'b0);
    checkFlag("wfi_after_wake_no_trap", trap_taken, 1'b0);
    tmr_irq = 1'b0;
    repeat (LAT + 1) tick();
    writeCsr(4'd3, 12'h300, 32'd0, 5'd8);
    pc_ex = 32'h300;
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    pc_ex = 32'h308;
    runWfi(cyc, tseen);
    checkOutput("wfi2_sleep_cycles", cyc, 32'(10 + LAT));
    checkFlag("wfi2_trap_seen", tseen, 1'b1);
    tmr_irq = 1'b0;
    readCsr("wfi2_mepc", 12'h341, 32'h304);
    readCsr("wfi2_mstatus", 12'h300, 32'h0000_1880);

    $display("[TB] reset while sleeping");
    doReset();
    writeCsr(4'd0, 12'h304, 32'h0000_0080, 5'd0);
    wfi = 1'b1;
    tick();
    wfi = 1'b0;
    repeat (3) tick();
    #1;
    checkFlag("rst_wfi_sleeping", wfi_stall, 1'b1);
    rstn = 1'b0;
    #1;
    checkFlag("rst_wfi_abort", wfi_stall, 1'b0);
    tick();
    rstn = 1'b1;
    tmr_irq = 1'b1;
    repeat (LAT + 1) tick();
    #1;
    checkFlag("rst_wfi_no_trap", trap_taken, 1'b0);
    checkFlag("rst_wfi_run", wfi_stall, 1'b0);
    tmr_irq = 1'b0;

    $display("[TB] interrupt against stall, MRET and mepc write");
    doReset();
    writeCsr(4'd0, 12'h304, 32'h0000_0080, 5'd0);
    writeCsr(4'd3, 12'h300, 32'd0, 5'd8);
    pc_ex = 32'h400;
    stall = 1'b1;
    tmr_irq = 1'b1;
    mret = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'd0, 12'h341, 32'hABCD_0000, 5'd0);
    for (int i = 0; i < LAT + 2; i++) begin
      #1;
      checkFlag("stall_no_trap", trap_taken, 1'b0);
      checkFlag("stall_no_mret", mret_taken, 1'b0);
      tick();
    end
    stall = 1'b0;
    #1;
    checkFlag("race_trap", trap_taken, 1'b1);
    checkFlag("race_no_mret", mret_taken, 1'b0);
    checkOutput("race_redirect", redirect_pc, 32'h0001_0000);
    tick();
    mret = 1'b0;
    tmr_irq = 1'b0;
    readCsr("race_mepc", 12'h341, 32'h400);
    readCsr("race_mstatus", 12'h300, 32'h0000_1880);

    $display("[TB] randomized CSR traffic against reference model");
    doReset();
    for (int n = 0; n < 400; n++) begin
      c  = 4'($urandom_range(0, 9));
      a  = addrs[$urandom_range(0, 13)];
      r  = $urandom;
      u  = 5'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      w  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) == 0);
      rt = 1'($urandom_range(0, 1));
      applyStimulus(v, w, c, a, r, u);
      stall  = s;
      retire = rt;
      case (c)
        4'd6:    expv = m_cycle[31:0];
        4'd7:    expv = m_instret[31:0];
        4'd8:    expv = m_cycle[63:32];
        4'd9:    expv = m_instret[63:32];
        default: expv = modelRead(a);
      endcase
      #1;
      checkOutput($sformatf("rand%0d_rdata", n), csr_rdata, expv);
      checkFlag("rand_no_trap", trap_taken, 1'b0);
      cw = 1'b0;
      iw = 1'b0;
      if (v && w && !s && c <= 4'd5) begin
        s_src = (c <= 4'd2) ? r : {27'd0, u};
        oldv  = modelRead(a);
        case (c)
          4'd0, 4'd3: newv = s_src;
          4'd1, 4'd4: newv = oldv | s_src;
          default:    newv = oldv & ~s_src;
        endcase
        case (a)
          12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
          12'h304: begin m_meie = newv[11]; m_mtie = newv[7]; end
          12'h341: m_mepc = newv & 32'hFFFF_FFFC;
          12'hB00: begin m_cycle[31:0]    = newv; cw = 1'b1; end
          12'hB80: begin m_cycle[63:32]   = newv; cw = 1'b1; end
          12'hB02: begin m_instret[31:0]  = newv; iw = 1'b1; end
          12'hB82: begin m_instret[63:32] = newv; iw = 1'b1; end
          default: ;
        endcase
      end
      if (!cw) m_cycle = m_cycle + 64'd1;
      if (!iw && rt) m_instret = m_instret + 64'd1;
      tick();
    end
    idle();
    stall = 1'b0;
    retire = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rstn in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: csr_valid in 1, CSR instruction in EX; csr_we in 1, write enable; csr_ctrl in 4, op code 0..9 (0 RW, 1 RS, 2 RC, 3 RWI, 4 RSI, 5 RCI, 6 CYCLE, 7 INSTRET, 8 CYCLEH, 9 INSTRETH).
REQ-003 SHALL have ports: csr_addr in 12; rs1_data in 32; uimm in 5; mret in 1; wfi in 1; pc_ex in 32, PC of EX instruction; stall in 1, pipeline/memory wait.
REQ-004 SHALL have ports: retire in 1, instruction-retired pulse; ext_irq in 1; tmr_irq in 1.
REQ-005 SHALL have ports: csr_rdata out 32; trap_taken out 1; mret_taken out 1; redirect_pc out 32; wfi_stall out 1.

Function
REQ-006 SHALL implement mstatus 0x300 (MIE b3, MPIE b7, MPP b12:11 fixed 2'b11), mie 0x304 (MEIE b11, MTIE b7), mtvec 0x305 read-only 0x0001_0000, mepc 0x341 (b1:0 read 0), mip 0x344 read-only (MEIP b11, MTIP b7).
REQ-007 SHALL implement 64-bit mcycle/minstret at 0xB00/0xB02/0xB80/0xB82, with read-only aliases 0xC00/0xC02/0xC80/0xC82; other addresses read 0, ignore writes.
REQ-008 csr_rdata SHALL be combinational old value: by csr_addr for csr_ctrl 0..5; codes 6..9 SHALL force mcycle[31:0], minstret[31:0], mcycle[63:32], minstret[63:32].
REQ-009 Write (csr_valid & csr_we & ~stall) SHALL commit at next edge: RW new=src, RS old|src, RC old&~src; src=rs1_data for 0..2, {27'b0,uimm} for 3..5.
REQ-010 mcycle SHALL increment every cycle incl. stall; minstret SHALL increment when retire=1; both wrap at 2^64; a write to either half SHALL override that cycle's increment for the full 64 bits.
REQ-011 FSM states RUN, WFI_WAIT; RUN->WFI_WAIT on wfi & ~stall; WFI_WAIT->RUN when (mip & mie)!=0, independent of MIE; wfi_stall=1 exactly while in WFI_WAIT.
REQ-012 Interrupt take: pending=(mip&mie)!=0 & mstatus.MIE & ~stall; SHALL pulse trap_taken 1 cycle, redirect_pc=mtvec, MPIE<=MIE, MIE<=0.
REQ-013 On take, mepc SHALL load pc_ex in RUN, and the WFI PC+4 (latched on WFI entry) in WFI_WAIT.
REQ-014 MRET (mret & ~stall & no interrupt take) SHALL pulse mret_taken 1 cycle, redirect_pc=mepc, MIE<=MPIE, MPIE<=1.
REQ-015 Interrupt take SHALL win over simultaneous MRET, WFI entry, or CSR write to mstatus/mie/mepc (those discarded; mepc=pc_ex).
REQ-016 trap_taken and mret_taken SHALL never be high together; redirect_pc SHALL be 0 when neither is high.
REQ-017 While stall=1 no architectural CSR except counters and mip SHALL change.

Reset
REQ-018 On rstn low: FSM RUN; mstatus MIE=0, MPIE=0; mie=0; mepc=0; counters=0; irq sync flops=0; all outputs 0.
REQ-019 Reset assertion mid-WFI or mid-trap SHALL abort immediately to RUN with no trap pulse after release.

Configuration
REQ-020 With CSR_IRQ_SYNC_EN defined, ext_irq/tmr_irq SHALL pass a 2-flop synchronizer (mip latency 2 cycles); without it, a single register (latency 1 cycle).

Structure
REQ-021 Package csr_pkg SHALL hold CSR address constants, csr_ctrl enum, FSM state enum, MTVEC_RESET constant, mstatus/mip bit indices.
REQ-022 Sub-module csr_counter64 (64-bit counter, inc enable, per-half write) SHALL be instantiated twice.

Verification
REQ-023 CSRRW 0x341 rs1=0x1234_5678, then csrr -> rdata 0x1234_5678 old-then-new; reads back 0x1234_5678 (b1:0 masked: 0x1234_5678).
REQ-024 mcycle write 0xFFFF_FFFF to 0xB00 with mcycleh=0 -> next cycles 0x1_0000_0000, 0x1_0000_0001 (carry into high).
REQ-025 MIE=1, MEIE=1, ext_irq rise, pc_ex=0x200 -> trap_taken 1 cycle at sync latency, redirect_pc 0x0001_0000, mepc 0x200, MIE 0, MPIE 1; then MRET -> redirect_pc 0x200, MIE 1.
REQ-026 WFI at PC 0x300 with MIE=0, MTIE=1, tmr_irq after 10 cycles -> wfi_stall high 10+latency cycles, return RUN, no trap; repeat with MIE=1 -> trap, mepc 0x304.
REQ-027 Simultaneous MRET and pending interrupt -> trap_taken only, mret_taken 0, mepc=pc_ex; stall=1 during pending interrupt -> no trap until stall drops.
